id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline stage that directly feeds the EX-stage ALU: operands, ALU control and downstream control bits.
- Registers decoded ID fields with stall/flush control.
- Forwards results from EX/MEM and MEM/WB onto ALU operands.
- Detects load-use hazards and requests an IF/ID freeze.

Parameters:
- DW, 32, data/operand width
- RW, 5, register-address width
- CW, 4, ALU control width (matches ALU ctrl encoding; 4'b0010 = add)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset
- stall_i  in  1  global hold (e.g. memory miss); freezes stage
- flush_i  in  1  insert bubble (taken branch)
- id_valid_i  in  1  ID holds a real instruction
- id_rs1_data_i  in  DW  regfile read 1
- id_rs2_data_i  in  DW  regfile read 2
- id_imm_i  in  DW  sign-extended immediate
- id_alusrc_i  in  1  1: operand 2 = imm
- id_alu_ctrl_i  in  CW  ALU operation
- id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i  in  RW each  source/dest regs
- id_regwrite_i, id_memread_i, id_memwrite_i, id_memtoreg_i  in  1 each  control
- exmem_rd_i  in  RW, exmem_regwrite_i  in  1, exmem_result_i  in  DW  EX/MEM producer
- memwb_rd_i  in  RW, memwb_regwrite_i  in  1, memwb_result_i  in  DW  MEM/WB producer
- alu_data1_o  out  DW  to ALU data1
- alu_data2_o  out  DW  to ALU data2
- alu_ctrl_o  out  CW  to ALU control
- ex_rs2_data_o  out  DW  forwarded rs2 (store data)
- ex_rd_o  out  RW; ex_regwrite_o, ex_memread_o, ex_memwrite_o, ex_memtoreg_o  out  1 each
- ex_valid_o  out  1  EX holds a real instruction
- hazard_stall_o  out  1  to IF/ID: hold PC and IF/ID

Behaviour:
- Single clock; reset is synchronous and active-high on rst_i.
- Latency: 1 cycle ID→EX. Forwarding and hazard logic are combinational from registered state plus inputs.
- Update priority at posedge clk_i:
  - rst_i: all fields cleared; alu_ctrl reg = 4'b0010, valid = 0.
  - else stall_i: hold every field.
  - else flush_i or hazard_stall_o: bubble. Valid = 0, all control bits = 0, data/addr = 0, alu_ctrl = 4'b0010.
  - else: load all ID fields. Valid = id_valid_i; control bits are ANDed with id_valid_i.
- Reset values: every output 0 except alu_ctrl_o = 4'b0010. hazard_stall_o = 0 because valid = 0.
- Forward select, per source (rs1, rs2), using registered addresses:
  - EX/MEM if exmem_regwrite_i, exmem_rd_i != 0 and address match.
  - else MEM/WB if memwb_regwrite_i, memwb_rd_i != 0 and address match.
  - else registered regfile data.
  - EX/MEM always beats MEM/WB. Register 0 is never forwarded.
- alu_data1_o = fwd rs1. ex_rs2_data_o = fwd rs2. alu_data2_o = alusrc ? imm : fwd rs2.
- Load-use: hazard_stall_o = id_valid_i & ex_valid_o & ex_memread_o & ex_rd_o != 0 & (ex_rd_o == id_rs1_addr_i | ex_rd_o == id_rs2_addr_i). Deliberately conservative: rs2 is checked even for immediate forms.
- stall_i together with hazard: stall wins and the stage holds; hazard_stall_o stays asserted.
- flush_i together with hazard: single bubble.
- Reset mid-stall: reset wins at the next edge.

Optional Feature:
- Macro FWD_EN.
- Defined: forwarding as above.
- Undefined:
  - No forwarding: outputs use registered data directly.
  - hazard_stall_o also asserts when id_valid_i and a nonzero id_rs1/id_rs2 matches either ex_rd_o (ex_valid_o & ex_regwrite_o) or exmem_rd_i (exmem_regwrite_i).
  - MEM/WB is resolved by the write-first register file.

Test Plan:
- Reset: rst_i=1 for 1 cycle → ex_valid_o=0, all control 0, alu_ctrl_o=4'b0010, hazard_stall_o=0.
- Pass: id rs1_data=5, rs2_data=7, alusrc=0, ctrl=0010, rd=3, valid → next cycle alu_data1_o=5, alu_data2_o=7, ex_rd_o=3, ex_valid_o=1.
- Forward (FWD_EN), with ex rs1=4:
  - exmem rd=4, regwrite, result 0x11, and memwb rd=4, result 0x22 → alu_data1_o=0x11.
  - Drop exmem_regwrite_i → 0x22.
  - ex rs1=0 → regfile value.
- Load-use: EX holds load with rd=6; ID rs2=6, valid → hazard_stall_o=1; next cycle ex_valid_o=0; the following cycle the held instruction loads.
- Stall/flush: stall_i=1 for 3 cycles with changing ID inputs → outputs constant. stall_i=1 with flush_i=1 → hold. flush_i alone → bubble.
- Immediate: alusrc=1, imm=0xFFFFFFF0, rs2 forwarded 0x33 → alu_data2_o=0xFFFFFFF0, ex_rs2_data_o=0x33.

Source files
------------

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX register with operand forwarding and load-use hazard detection (forwarding enabled by macro FWD_EN)
module id_ex_stage #(
  parameter int DW = 32,
  parameter int RW = 5,
  parameter int CW = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          stall_i,
  input  logic          flush_i,
  input  logic          id_valid_i,
  input  logic [DW-1:0] id_rs1_data_i,
  input  logic [DW-1:0] id_rs2_data_i,
  input  logic [DW-1:0] id_imm_i,
  input  logic          id_alusrc_i,
  input  logic [CW-1:0] id_alu_ctrl_i,
  input  logic [RW-1:0] id_rs1_addr_i,
  input  logic [RW-1:0] id_rs2_addr_i,
  input  logic [RW-1:0] id_rd_addr_i,
  input  logic          id_regwrite_i,
  input  logic          id_memread_i,
  input  logic          id_memwrite_i,
  input  logic          id_memtoreg_i,
  input  logic [RW-1:0] exmem_rd_i,
  input  logic          exmem_regwrite_i,
  input  logic [DW-1:0] exmem_result_i,
  input  logic [RW-1:0] memwb_rd_i,
  input  logic          memwb_regwrite_i,
  input  logic [DW-1:0] memwb_result_i,
  output logic [DW-1:0] alu_data1_o,
  output logic [DW-1:0] alu_data2_o,
  output logic [CW-1:0] alu_ctrl_o,
  output logic [DW-1:0] ex_rs2_data_o,
  output logic [RW-1:0] ex_rd_o,
  output logic          ex_regwrite_o,
  output logic          ex_memread_o,
  output logic          ex_memwrite_o,
  output logic          ex_memtoreg_o,
  output logic          ex_valid_o,
  output logic          hazard_stall_o
);
  typedef struct packed {
    logic          valid;
    logic [DW-1:0] rs1_data;
    logic [DW-1:0] rs2_data;
    logic [DW-1:0] imm;
    logic          alusrc;
    logic [CW-1:0] alu_ctrl;
    logic [RW-1:0] rs1_addr;
    logic [RW-1:0] rs2_addr;
    logic [RW-1:0] rd;
    logic          regwrite;
    logic          memread;
    logic          memwrite;
    logic          memtoreg;
  } ex_t;
  ex_t ex_q, ex_d, bubble, load;
  logic load_use, hazard;
  logic [DW-1:0] fwd1, fwd2;
  // Bubble is an add with everything else zeroed; load gates control with valid
  always_comb begin
    bubble = '0;
    bubble.alu_ctrl = CW'(4'b0010);
    load = '{valid: id_valid_i, rs1_data: id_rs1_data_i, rs2_data: id_rs2_data_i,
             imm: id_imm_i, alusrc: id_alusrc_i, alu_ctrl: id_alu_ctrl_i,
             rs1_addr: id_rs1_addr_i, rs2_addr: id_rs2_addr_i, rd: id_rd_addr_i,
             regwrite: id_regwrite_i & id_valid_i, memread: id_memread_i & id_valid_i,
             memwrite: id_memwrite_i & id_valid_i, memtoreg: id_memtoreg_i & id_valid_i};
    ex_d = stall_i ? ex_q : (flush_i | hazard) ? bubble : load;
  end
  // Stage register: reset beats stall, stall beats flush/hazard
  always_ff @(posedge clk_i) begin
    if (rst_i) ex_q <= bubble;
    else ex_q <= ex_d;
  end
  assign load_use = id_valid_i & ex_q.valid & ex_q.memread & (ex_q.rd != '0) &
                    ((ex_q.rd == id_rs1_addr_i) | (ex_q.rd == id_rs2_addr_i));
`ifdef FWD_EN
  function automatic logic [DW-1:0] fwd(input logic [RW-1:0] a, input logic [DW-1:0] r);
    return (exmem_regwrite_i && exmem_rd_i != '0 && exmem_rd_i == a) ? exmem_result_i :
           (memwb_regwrite_i && memwb_rd_i != '0 && memwb_rd_i == a) ? memwb_result_i : r;
  endfunction
  assign fwd1   = fwd(ex_q.rs1_addr, ex_q.rs1_data);
  assign fwd2   = fwd(ex_q.rs2_addr, ex_q.rs2_data);
  assign hazard = load_use;
`else
  // Without forwarding, any pending write from EX or EX/MEM to a source must drain first;
  // MEM/WB is covered by the write-first register file
  function automatic logic dep(input logic [RW-1:0] a);
    return (a != '0) & ((ex_q.valid & ex_q.regwrite & (ex_q.rd == a)) |
                        (exmem_regwrite_i & (exmem_rd_i == a)));
  endfunction
  logic unused_memwb;
  assign unused_memwb = ^{memwb_rd_i, memwb_regwrite_i, memwb_result_i, exmem_result_i};
  assign fwd1   = ex_q.rs1_data;
  assign fwd2   = ex_q.rs2_data;
  assign hazard = load_use | (id_valid_i & (dep(id_rs1_addr_i) | dep(id_rs2_addr_i)));
`endif
  assign alu_data1_o    = fwd1;
  assign alu_data2_o    = ex_q.alusrc ? ex_q.imm : fwd2;
  assign alu_ctrl_o     = ex_q.alu_ctrl;
  assign ex_rs2_data_o  = fwd2;
  assign ex_rd_o        = ex_q.rd;
  assign ex_regwrite_o  = ex_q.regwrite;
  assign ex_memread_o   = ex_q.memread;
  assign ex_memwrite_o  = ex_q.memwrite;
  assign ex_memtoreg_o  = ex_q.memtoreg;
  assign ex_valid_o     = ex_q.valid;
  assign hazard_stall_o = hazard;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: vector table, directed corner sequences and a randomized reference-model run for id_ex_stage
module tb_id_ex_stage;
  logic clk_i = 0, rst_i, stall_i, flush_i, id_valid_i, id_alusrc_i;
  logic [31:0] id_rs1_data_i, id_rs2_data_i, id_imm_i, exmem_result_i, memwb_result_i;
  logic [3:0] id_alu_ctrl_i;
  logic [4:0] id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i, exmem_rd_i, memwb_rd_i;
  logic id_regwrite_i, id_memread_i, id_memwrite_i, id_memtoreg_i, exmem_regwrite_i, memwb_regwrite_i;
  logic [31:0] alu_data1_o, alu_data2_o, ex_rs2_data_o;
  logic [3:0] alu_ctrl_o;
  logic [4:0] ex_rd_o;
  logic ex_regwrite_o, ex_memread_o, ex_memwrite_o, ex_memtoreg_o, ex_valid_o, hazard_stall_o;
  int n_chk = 0, n_err = 0;
  id_ex_stage dut (.clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
    .id_valid_i(id_valid_i), .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i),
    .id_imm_i(id_imm_i), .id_alusrc_i(id_alusrc_i), .id_alu_ctrl_i(id_alu_ctrl_i),
    .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i), .id_rd_addr_i(id_rd_addr_i),
    .id_regwrite_i(id_regwrite_i), .id_memread_i(id_memread_i), .id_memwrite_i(id_memwrite_i),
    .id_memtoreg_i(id_memtoreg_i), .exmem_rd_i(exmem_rd_i), .exmem_regwrite_i(exmem_regwrite_i),
    .exmem_result_i(exmem_result_i), .memwb_rd_i(memwb_rd_i), .memwb_regwrite_i(memwb_regwrite_i),
    .memwb_result_i(memwb_result_i), .alu_data1_o(alu_data1_o), .alu_data2_o(alu_data2_o),
    .alu_ctrl_o(alu_ctrl_o), .ex_rs2_data_o(ex_rs2_data_o), .ex_rd_o(ex_rd_o),
    .ex_regwrite_o(ex_regwrite_o), .ex_memread_o(ex_memread_o), .ex_memwrite_o(ex_memwrite_o),
    .ex_memtoreg_o(ex_memtoreg_o), .ex_valid_o(ex_valid_o), .hazard_stall_o(hazard_stall_o));
  always #5 clk_i = ~clk_i;
  typedef struct {
    logic valid, alusrc, rw, mr, mw, mt;
    logic [31:0] rs1d, rs2d, imm;
    logic [3:0] ctrl;
    logic [4:0] rs1a, rs2a, rd;
  } instr_t;
  typedef struct {
    logic [31:0] rs1d, rs2d, imm;
    logic alusrc;
    logic [3:0] ctrl;
    logic [4:0] rd;
    logic valid, rw, mr, mw, mt;
    logic [31:0] e_d1, e_d2;
    logic e_valid, e_rw, e_mr, e_mw, e_mt;
  } vec_t;
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask
  task automatic idle;
    {rst_i, stall_i, flush_i, id_valid_i, id_alusrc_i, id_regwrite_i, id_memread_i, id_memwrite_i, id_memtoreg_i} = '0;
    {id_rs1_data_i, id_rs2_data_i, id_imm_i, id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i} = '0;
    id_alu_ctrl_i = 4'b0010;
    {exmem_rd_i, exmem_regwrite_i, exmem_result_i, memwb_rd_i, memwb_regwrite_i, memwb_result_i} = '0;
  endtask
  task automatic drive(input instr_t i);
    id_valid_i = i.valid; id_alusrc_i = i.alusrc; id_regwrite_i = i.rw; id_memread_i = i.mr;
    id_memwrite_i = i.mw; id_memtoreg_i = i.mt; id_rs1_data_i = i.rs1d; id_rs2_data_i = i.rs2d;
    id_imm_i = i.imm; id_alu_ctrl_i = i.ctrl; id_rs1_addr_i = i.rs1a; id_rs2_addr_i = i.rs2a;
    id_rd_addr_i = i.rd;
  endtask
  function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] r);
`ifdef FWD_EN
    if (exmem_regwrite_i && exmem_rd_i != 0 && exmem_rd_i == a) return exmem_result_i;
    if (memwb_regwrite_i && memwb_rd_i != 0 && memwb_rd_i == a) return memwb_result_i;
`endif
    return r;
  endfunction
  function automatic logic model_haz(input instr_t m);
    logic h;
    h = id_valid_i && m.valid && m.mr && m.rd != 0 && (m.rd == id_rs1_addr_i || m.rd == id_rs2_addr_i);
`ifndef FWD_EN
    foreach (m.rd[k]) begin end
    if (id_valid_i && id_rs1_addr_i != 0 && ((m.valid && m.rw && m.rd == id_rs1_addr_i) ||
        (exmem_regwrite_i && exmem_rd_i == id_rs1_addr_i))) h = 1;
    if (id_valid_i && id_rs2_addr_i != 0 && ((m.valid && m.rw && m.rd == id_rs2_addr_i) ||
        (exmem_regwrite_i && exmem_rd_i == id_rs2_addr_i))) h = 1;
`endif
    return h;
  endfunction
  vec_t vt[5];
  instr_t ins, m, bub;
  logic [31:0] held_d1, exp_fw;
  logic [4:0] held_rd;
  logic h;
  initial begin
    vt[0] = '{32'h5, 32'h7, 32'h0, 1'b0, 4'b0010, 5'd3, 1, 1, 0, 0, 0, 32'h5, 32'h7, 1, 1, 0, 0, 0};
    vt[1] = '{32'hA, 32'hB, 32'h100, 1'b1, 4'b0110, 5'd9, 1, 1, 1, 0, 1, 32'hA, 32'h100, 1, 1, 1, 0, 1};
    vt[2] = '{32'hDEAD, 32'hBEEF, 32'h4, 1'b0, 4'b0000, 5'd0, 1, 0, 0, 1, 0, 32'hDEAD, 32'hBEEF, 1, 0, 0, 1, 0};
    vt[3] = '{32'h1, 32'h2, 32'h3, 1'b1, 4'b0001, 5'd31, 0, 1, 1, 1, 1, 32'h1, 32'h3, 0, 0, 0, 0, 0};
    vt[4] = '{32'hFFFFFFFF, 32'h80000000, 32'h0, 1'b0, 4'b0111, 5'd17, 1, 1, 0, 0, 1, 32'hFFFFFFFF, 32'h80000000, 1, 1, 0, 0, 1};
    idle();
    rst_i = 1;
    tick();
    rst_i = 0;
    #1;
    chk("reset_ctrl", {ex_valid_o, ex_regwrite_o, ex_memread_o, ex_memwrite_o, ex_memtoreg_o, hazard_stall_o, alu_ctrl_o}, {6'b0, 4'b0010});
    chk("reset_data", {alu_data1_o, alu_data2_o, ex_rs2_data_o, ex_rd_o}, '0);
    foreach (vt[k]) begin
      ins = '{vt[k].valid, vt[k].alusrc, vt[k].rw, vt[k].mr, vt[k].mw, vt[k].mt, vt[k].rs1d, vt[k].rs2d, vt[k].imm, vt[k].ctrl, 5'd0, 5'd0, vt[k].rd};
      drive(ins);
      tick();
      chk($sformatf("vec%0d_data", k), {alu_data1_o, alu_data2_o, ex_rs2_data_o}, {vt[k].e_d1, vt[k].e_d2, vt[k].rs2d});
      chk($sformatf("vec%0d_ctrl", k), {ex_valid_o, ex_regwrite_o, ex_memread_o, ex_memwrite_o, ex_memtoreg_o, alu_ctrl_o, ex_rd_o},
          {vt[k].e_valid, vt[k].e_rw, vt[k].e_mr, vt[k].e_mw, vt[k].e_mt, vt[k].ctrl, vt[k].rd});
    end
    idle();
    drive('{1, 0, 1, 0, 0, 0, 32'h5, 32'h7, 32'h0, 4'b0010, 5'd1, 5'd2, 5'd3});
    tick();
    chk("pass", {alu_data1_o, alu_data2_o, ex_rd_o, ex_valid_o}, {32'h5, 32'h7, 5'd3, 1'b1});
    drive('{1, 1, 1, 1, 0, 1, 32'h0, 32'h0, 32'h40, 4'b0010, 5'd0, 5'd0, 5'd6});
    tick();
    drive('{1, 0, 1, 0, 0, 0, 32'hA, 32'hB, 32'h0, 4'b0110, 5'd1, 5'd6, 5'd7});
    #1;
    chk("loaduse_haz", hazard_stall_o, 1'b1);
    tick();
    chk("loaduse_bubble", {ex_valid_o, ex_regwrite_o, alu_ctrl_o, ex_rd_o, hazard_stall_o}, {2'b00, 4'b0010, 5'd0, 1'b0});
    tick();
    chk("loaduse_resume", {ex_valid_o, ex_rd_o, alu_data1_o, alu_ctrl_o}, {1'b1, 5'd7, 32'hA, 4'b0110});
    held_d1 = 32'hA;
    held_rd = 5'd7;
    stall_i = 1;
    for (int c = 0; c < 3; c++) begin
      drive('{1, 0, 1, 0, 0, 0, $urandom, $urandom, $urandom, 4'($urandom), 5'd0, 5'd0, 5'(c + 10)});
      tick();
      chk($sformatf("stall%0d", c), {ex_valid_o, ex_rd_o, alu_data1_o}, {1'b1, held_rd, held_d1});
    end
    flush_i = 1;
    tick();
    chk("stall_flush_hold", {ex_valid_o, ex_rd_o, alu_data1_o}, {1'b1, held_rd, held_d1});
    stall_i = 0;
    tick();
    chk("flush_bubble", {ex_valid_o, ex_regwrite_o, ex_rd_o, alu_ctrl_o, alu_data1_o}, {2'b00, 5'd0, 4'b0010, 32'h0});
    idle();
    drive('{1, 0, 1, 0, 0, 0, 32'h99, 32'h0, 32'h0, 4'b0010, 5'd4, 5'd0, 5'd8});
    tick();
    id_valid_i = 0;
    exmem_rd_i = 4; exmem_regwrite_i = 1; exmem_result_i = 32'h11;
    memwb_rd_i = 4; memwb_regwrite_i = 1; memwb_result_i = 32'h22;
    #1;
`ifdef FWD_EN
    exp_fw = 32'h11;
`else
    exp_fw = 32'h99;
`endif
    chk("fwd_exmem", alu_data1_o, exp_fw);
    exmem_regwrite_i = 0;
    #1;
`ifdef FWD_EN
    exp_fw = 32'h22;
`else
    exp_fw = 32'h99;
`endif
    chk("fwd_memwb", alu_data1_o, exp_fw);
    idle();
    drive('{1, 0, 1, 0, 0, 0, 32'h55, 32'h0, 32'h0, 4'b0010, 5'd0, 5'd0, 5'd8});
    tick();
    id_valid_i = 0;
    exmem_regwrite_i = 1; exmem_result_i = 32'h11;
    memwb_regwrite_i = 1; memwb_result_i = 32'h22;
    #1;
    chk("fwd_r0", alu_data1_o, 32'h55);
    idle();
    drive('{1, 1, 1, 0, 0, 0, 32'h0, 32'h44, 32'hFFFFFFF0, 4'b0010, 5'd0, 5'd5, 5'd9});
    tick();
    id_valid_i = 0;
    exmem_rd_i = 5; exmem_regwrite_i = 1; exmem_result_i = 32'h33;
    #1;
`ifdef FWD_EN
    exp_fw = 32'h33;
`else
    exp_fw = 32'h44;
`endif
    chk("imm_data2", alu_data2_o, 32'hFFFFFFF0);
    chk("imm_store", ex_rs2_data_o, exp_fw);
    idle();
    bub = '{0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 4'b0010, 5'd0, 5'd0, 5'd0};
    rst_i = 1;
    tick();
    m = bub;
    for (int c = 0; c < 3000; c++) begin
      rst_i = ($urandom_range(63) == 0);
      stall_i = ($urandom_range(7) == 0);
      flush_i = ($urandom_range(7) == 0);
      ins = '{1'($urandom_range(3) != 0), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              $urandom, $urandom, $urandom, 4'($urandom), 5'($urandom_range(3)), 5'($urandom_range(3)), 5'($urandom_range(3))};
      drive(ins);
      exmem_rd_i = 5'($urandom_range(3)); exmem_regwrite_i = 1'($urandom); exmem_result_i = $urandom;
      memwb_rd_i = 5'($urandom_range(3)); memwb_regwrite_i = 1'($urandom); memwb_result_i = $urandom;
      #1;
      h = model_haz(m);
      chk("rand", {alu_data1_o, alu_data2_o, ex_rs2_data_o, alu_ctrl_o, ex_rd_o, ex_regwrite_o, ex_memread_o,
                   ex_memwrite_o, ex_memtoreg_o, ex_valid_o, hazard_stall_o},
                  {fwd(m.rs1a, m.rs1d), m.alusrc ? m.imm : fwd(m.rs2a, m.rs2d), fwd(m.rs2a, m.rs2d), m.ctrl, m.rd,
                   m.rw, m.mr, m.mw, m.mt, m.valid, h});
      @(posedge clk_i);
      if (rst_i) m = bub;
      else if (!stall_i) begin
        if (flush_i || h) m = bub;
        else begin
          m = ins;
          {m.rw, m.mr, m.mw, m.mt} = {ins.rw, ins.mr, ins.mw, ins.mt} & {4{ins.valid}};
        end
      end
      #1;
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
